// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and helpers for the matrix arbiter and its
//                requestor-side frontend: client state encoding, priority
//                entry indexing and age-level saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Per-client life cycle: idle, waiting for a grant, owning the channel
    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_WAIT = 2'd1,
        CS_OWN  = 2'd2
    } client_state_e;

    // Bit offset of priority entry (i,j) in the flattened priority matrix
    function automatic int prio_idx(input int i, input int j, input int n, input int pw);
        return (i * n + j) * pw;
    endfunction

    // Priority level of a waiter: age divided by 2^shift, clamped to the entry range
    function automatic int sat_level(input int age, input int shift, input int pw);
        int lvl;
        int lmax;
        lvl  = age >> shift;
        lmax = (1 << pw) - 1;
        return (lvl > lmax) ? lmax : lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_request_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : arb_request_frontend_if
//  Description : Bundle of client request, arbiter and downstream beat
//                signals around the request frontend. The frontend uses the
//                slave view; the surrounding environment uses the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface arb_request_frontend_if #(
    parameter int NUM_REQUESTORS = 4,
    parameter int PRIORITY_WIDTH = 2,
    parameter int BURST_W        = 3
);
    logic [NUM_REQUESTORS-1:0]                               cli_valid;
    logic [NUM_REQUESTORS*BURST_W-1:0]                       cli_len;
    logic [NUM_REQUESTORS-1:0]                               cli_ready;
    logic [NUM_REQUESTORS-1:0]                               req;
    logic [NUM_REQUESTORS*NUM_REQUESTORS*PRIORITY_WIDTH-1:0] priority_matrix;
    logic [NUM_REQUESTORS-1:0]                               grant;
    logic                                                    grant_valid;
    logic [NUM_REQUESTORS-1:0]                               xfer_owner;
    logic                                                    beat_valid;
    logic                                                    beat_last;
    logic                                                    beat_ready;

    // Environment side: clients, arbiter and downstream sink
    modport master (
        output cli_valid, cli_len, grant, grant_valid, beat_ready,
        input  cli_ready, req, priority_matrix, xfer_owner, beat_valid, beat_last
    );

    // Frontend side
    modport slave (
        input  cli_valid, cli_len, grant, grant_valid, beat_ready,
        output cli_ready, req, priority_matrix, xfer_owner, beat_valid, beat_last
    );
endinterface
`default_nettype wire

// File: rtl/arb_client_slot.sv
`default_nettype none
// ============================================================================
//  Module      : arb_client_slot
//  Description : One client's IDLE/WAIT/OWN state machine, burst length latch
//                and waiting-age counter. Age counting is compiled in only
//                when ARB_FRONTEND_AGING_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_client_slot
    import arb_pkg::*;
#(
    parameter int PRIORITY_WIDTH = 2,
    parameter int BURST_W        = 3,
    parameter int AGE_SHIFT      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cli_valid_i,
    input  logic [BURST_W-1:0]        cli_len_i,
    input  logic                      take_i,
    input  logic                      done_i,
    output logic                      cli_ready_o,
    output logic                      req_o,
    output logic                      wait_o,
    output logic                      own_o,
    output logic [BURST_W-1:0]        len_o,
    output logic [PRIORITY_WIDTH-1:0] level_o
);
    client_state_e      state_q;
    client_state_e      state_d;
    logic [BURST_W-1:0] len_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= CS_IDLE;
        else       state_q <= state_d;
    end

    // Next state: accept while idle, take ownership on a selected grant,
    // release on the final beat handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            CS_IDLE: if (cli_valid_i) state_d = CS_WAIT;
            CS_WAIT: if (take_i)      state_d = CS_OWN;
            CS_OWN:  if (done_i)      state_d = CS_IDLE;
            default:                  state_d = CS_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        cli_ready_o = (state_q == CS_IDLE);
        wait_o      = (state_q == CS_WAIT);
        own_o       = (state_q == CS_OWN);
        req_o       = (state_q == CS_WAIT) || (state_q == CS_OWN);
    end

    // Burst length is captured only on the accept handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  len_q <= '0;
        else if (state_q == CS_IDLE && cli_valid_i) len_q <= cli_len_i;
    end

    assign len_o = len_q;

`ifdef ARB_FRONTEND_AGING_EN
    localparam int AGE_W = AGE_SHIFT + PRIORITY_WIDTH;

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    // Age grows while waiting, is frozen while owning and clears on release
    always_comb begin
        age_d = age_q;
        case (state_q)
            CS_WAIT: if (age_q != {AGE_W{1'b1}}) age_d = age_q + AGE_W'(1);
            CS_OWN:  if (done_i)                 age_d = '0;
            default:                             age_d = '0;
        endcase
    end

    // Age register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) age_q <= '0;
        else       age_q <= age_d;
    end

    assign level_o = PRIORITY_WIDTH'(sat_level(int'(age_q), AGE_SHIFT, PRIORITY_WIDTH));
`else
    // Without aging every client sits permanently at level zero
    assign level_o = PRIORITY_WIDTH'(sat_level(0, AGE_SHIFT, PRIORITY_WIDTH));
`endif

endmodule
`default_nettype wire

// File: rtl/arb_request_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : arb_request_frontend
//  Description : Requestor-side companion of the matrix arbiter. Collects
//                client bursts, presents req and an age-based priority
//                matrix, picks the owner from the registered grant and
//                serialises the owner's burst onto one beat channel.
//                Optional feature macro: ARB_FRONTEND_AGING_EN (age counters
//                and priority matrix; when undefined the matrix is all zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_request_frontend
    import arb_pkg::*;
#(
    parameter int NUM_REQUESTORS = 4,
    parameter int PRIORITY_WIDTH = 2,
    parameter int BURST_W        = 3,
    parameter int AGE_SHIFT      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    arb_request_frontend_if.slave fe_if
);
    localparam int N = NUM_REQUESTORS;

    logic [N-1:0]              w_ready;
    logic [N-1:0]              w_req;
    logic [N-1:0]              w_wait;
    logic [N-1:0]              w_own;
    logic [N-1:0]              w_take;
    logic [BURST_W-1:0]        w_len   [N];
    logic [PRIORITY_WIDTH-1:0] w_level [N];

    logic               w_any_own;
    logic [BURST_W-1:0] w_owner_len;
    logic               w_beat_hs;
    logic               w_beat_last;
    logic               w_done;
    logic [BURST_W-1:0] count_q;
    logic [BURST_W-1:0] count_d;

    genvar gi;
    genvar gj;

    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            arb_client_slot #(
                .PRIORITY_WIDTH (PRIORITY_WIDTH),
                .BURST_W        (BURST_W),
                .AGE_SHIFT      (AGE_SHIFT)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .cli_valid_i (fe_if.cli_valid[gi]),
                .cli_len_i   (fe_if.cli_len[gi*BURST_W +: BURST_W]),
                .take_i      (w_take[gi]),
                .done_i      (w_done),
                .cli_ready_o (w_ready[gi]),
                .req_o       (w_req[gi]),
                .wait_o      (w_wait[gi]),
                .own_o       (w_own[gi]),
                .len_o       (w_len[gi]),
                .level_o     (w_level[gi])
            );
        end
    endgenerate

    // Owner length: ownership is one-hot, so an AND-OR mux is sufficient
    always_comb begin
        w_owner_len = '0;
        for (int i = 0; i < N; i++) begin
            w_owner_len = w_owner_len | (w_len[i] & {BURST_W{w_own[i]}});
        end
    end

    assign w_any_own   = |w_own;
    assign w_beat_hs   = w_any_own & fe_if.beat_ready;
    assign w_beat_last = w_any_own & (count_q == w_owner_len);
    assign w_done      = w_beat_hs & w_beat_last;

    // Owner selection: lowest-indexed waiting client with its grant set.
    // The channel counts as free on the final-beat edge of the current owner
    // too, so a pending grant hands over without an empty cycle. Grant bits
    // of idle or owning clients never qualify, which filters stale grants.
    always_comb begin
        logic found;
        found  = 1'b0;
        w_take = '0;
        if (fe_if.grant_valid && (!w_any_own || w_done)) begin
            for (int i = 0; i < N; i++) begin
                if (!found && w_wait[i] && fe_if.grant[i]) begin
                    w_take[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    // Beat counter next value: advance per handshake, rewind on the last beat
    always_comb begin
        count_d = count_q;
        if (w_beat_hs) count_d = w_beat_last ? '0 : count_q + BURST_W'(1);
    end

    // Beat counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    // Priority matrix: row i carries client i's level, diagonal is zero
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                localparam int IDX = prio_idx(gi, gj, N, PRIORITY_WIDTH);
                if (gi == gj) begin : g_diag
                    assign fe_if.priority_matrix[IDX +: PRIORITY_WIDTH] = '0;
                end else begin : g_off
                    assign fe_if.priority_matrix[IDX +: PRIORITY_WIDTH] = w_level[gi];
                end
            end
        end
    endgenerate

    assign fe_if.cli_ready  = w_ready;
    assign fe_if.req        = w_req;
    assign fe_if.xfer_owner = w_own;
    assign fe_if.beat_valid = w_any_own;
    assign fe_if.beat_last  = w_beat_last;

endmodule
`default_nettype wire
